// File: rtl/alu_resp_if.sv
// alu_resp_if: request/response channel bundle for alu_resp.
// The requester uses the master modport and alu_resp uses the slave modport.
interface alu_resp_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [2:0]       req_aluc;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_zero;
  logic             rsp_over;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_aluc, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_over, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluc, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_over, rsp_tag
  );
endinterface

// File: rtl/alu_resp.sv
// alu_resp: one-stage pipelined ALU whose results drain through a DEPTH-entry FIFO.
// Define ALU_RESP_STATS_EN to build the ops_done response counter; otherwise it reads 0.
module alu_resp #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_resp_if.slave   bus,
  output logic [15:0] ops_done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        aluc;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              over;
    logic              zero;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Pipeline and FIFO state.
  logic             s1_valid_q, s1_valid_d;
  req_t             s1_q, s1_d;
  rsp_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ_d;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] res;
  logic              res_over;
  rsp_t              res_entry;

  // ALU evaluated from the S1 operand register, written straight into the FIFO tail.
  always_comb begin
    res      = '0;
    res_over = 1'b0;
    sum      = s1_q.a + s1_q.b;
    diff     = s1_q.a - s1_q.b;
    case (op_e'(s1_q.aluc))
      OP_ADD: begin
        res      = sum;
        res_over = (s1_q.a[DATA_W-1] == s1_q.b[DATA_W-1]) &&
                   (sum[DATA_W-1] != s1_q.a[DATA_W-1]);
      end
      OP_SUB: begin
        res      = diff;
        res_over = (s1_q.a[DATA_W-1] != s1_q.b[DATA_W-1]) &&
                   (diff[DATA_W-1] != s1_q.a[DATA_W-1]);
      end
      OP_AND:  res = s1_q.a & s1_q.b;
      OP_OR:   res = s1_q.a | s1_q.b;
      OP_XOR:  res = s1_q.a ^ s1_q.b;
      OP_NOR:  res = ~(s1_q.a | s1_q.b);
      OP_SLT:  res = {31'd0, ($signed(s1_q.a) < $signed(s1_q.b))};
      OP_SLTU: res = {31'd0, (s1_q.a < s1_q.b)};
      default: res = '0;
    endcase
    res_entry.tag  = s1_q.tag;
    res_entry.over = res_over;
    res_entry.zero = (res == '0);
    res_entry.data = res;
  end

  // Handshakes and next-state bookkeeping; ready and valid come only from registers.
  always_comb begin
    accept      = bus.req_valid && req_ready_q;
    push        = s1_valid_q;
    pop         = rsp_valid_q && bus.rsp_ready;

    s1_valid_d  = accept;
    s1_d        = s1_q;
    if (accept) begin
      s1_d.a    = bus.req_a;
      s1_d.b    = bus.req_b;
      s1_d.aluc = bus.req_aluc;
      s1_d.tag  = bus.req_tag;
    end

    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    occ_d       = OCC_W'(count_d) + OCC_W'(s1_valid_d);
    req_ready_d = (occ_d < OCC_W'(DEPTH));
    rsp_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Entries are cleared on reset so the idle head reads as all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= res_entry;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = fifo_q[rd_ptr_q].data;
  assign bus.rsp_zero  = fifo_q[rd_ptr_q].zero;
  assign bus.rsp_over  = fifo_q[rd_ptr_q].over;
  assign bus.rsp_tag   = fifo_q[rd_ptr_q].tag;

`ifdef ALU_RESP_STATS_EN
  logic [15:0] ops_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_q <= '0;
    end else if (pop) begin
      ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign ops_done = ops_done_q;
`else
  assign ops_done = 16'd0;
`endif

  // Occupancy bookkeeping must never overrun the FIFO or desync valid from count.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CNT_W'(DEPTH))));
  a_valid_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q == (count_q != '0));

endmodule

// File: tb/tb_alu_resp.sv
// tb_alu_resp: directed self-checking bench for alu_resp (reset, ops, backpressure, wrap, stats).
module tb_alu_resp;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             over;
    logic             zero;
    logic [31:0]      data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ops_done;

  alu_resp_if #(.TAG_W(TAG_W)) bus ();

  alu_resp #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  int   hs_cnt  = 0;
  logic mon_en  = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response handshake is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      hs_cnt++;
      if (mon_en) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_tag), 64'hdead);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_in_order",
              64'({bus.rsp_tag, bus.rsp_over, bus.rsp_zero, bus.rsp_data}),
              64'(mon_e));
        end
      end
    end
  end

  task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [TAG_W-1:0] tag, input logic [31:0] ed,
                          input logic eo, output int waits);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_aluc  = op;
    bus.req_tag   = tag;
    waits = 0;
    while (!bus.req_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", 64'(bus.req_ready), 64'd1);
    end else begin
      exp_q.push_back({tag, eo, (ed == 32'd0), ed});
      tick();
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // One isolated op: accept, check the 2-edge latency, then let it pop.
  task automatic do_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input logic [31:0] ed, input logic ez, input logic eo);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_aluc  = op;
    bus.req_tag   = tag;
    chk("dir_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("dir_not_yet_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("dir_valid", 64'(bus.rsp_valid), 64'd1);
    chk(name, 64'({bus.rsp_tag, bus.rsp_over, bus.rsp_zero, bus.rsp_data}),
        64'({tag, eo, ez, ed}));
    tick();
    chk("dir_popped", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int low;
    int stale;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluc  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      bus.req_a     = $urandom;
    end
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_fields", 64'({bus.rsp_tag, bus.rsp_over, bus.rsp_zero, bus.rsp_data}), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    chk("rel_ready_before_edge", 64'(bus.req_ready), 64'd0);
    tick();
    chk("rel_ready_after_edge", 64'(bus.req_ready), 64'd1);

    // Directed ops with hand-computed results.
    do_dir("add_ovf",  32'h7fffffff, 32'h7fffffff, OP_ADD,  4'd0, 32'hfffffffe, 1'b0, 1'b1);
    do_dir("sub_ovf",  32'h01ffffff, 32'h80000000, OP_SUB,  4'd1, 32'h81ffffff, 1'b0, 1'b1);
    do_dir("and",      32'h0555ffff, 32'h0aaabbbb, OP_AND,  4'd2, 32'h0000bbbb, 1'b0, 1'b0);
    do_dir("or",       32'h0555ffff, 32'h0aaabbbb, OP_OR,   4'd3, 32'h0fffffff, 1'b0, 1'b0);
    do_dir("sub_zero", 32'h00000005, 32'h00000005, OP_SUB,  4'd4, 32'h00000000, 1'b1, 1'b0);
    do_dir("slt",      32'hffffffff, 32'h00000001, OP_SLT,  4'd5, 32'h00000001, 1'b0, 1'b0);
    do_dir("sltu",     32'hffffffff, 32'h00000001, OP_SLTU, 4'd6, 32'h00000000, 1'b1, 1'b0);
    do_dir("xor",      32'hff00ff00, 32'h0ff00ff0, OP_XOR,  4'd7, 32'hf0f0f0f0, 1'b0, 1'b0);
    do_dir("nor",      32'h00000000, 32'h00000000, OP_NOR,  4'd8, 32'hffffffff, 1'b0, 1'b0);
    do_dir("add_wrap", 32'hffffffff, 32'h00000001, OP_ADD,  4'd9, 32'h00000000, 1'b1, 1'b0);

    // Backpressure: only DEPTH requests fit while the consumer stalls.
    mon_en = 1'b1;
    n_rsp  = 0;
    bus.rsp_ready = 1'b0;
    stalls = 0;
    for (int t = 0; t < 4; t++) begin
      push_req(32'(t * 16 + 1), 32'd2, OP_ADD, TAG_W'(t), 32'(t * 16 + 3), 1'b0, w);
      stalls += w;
    end
    chk("bp_first4_no_stall", 64'(stalls), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'(4 * 16 + 1);
    bus.req_b     = 32'd2;
    bus.req_aluc  = OP_ADD;
    bus.req_tag   = TAG_W'(4);
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_ready_still_low", 64'(bus.req_ready), 64'd0);
    chk("bp_head_stable", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_data}), 64'({1'b1, 4'd0, 32'd3}));
    bus.rsp_ready = 1'b1;
    for (int t = 4; t < 8; t++) begin
      push_req(32'(t * 16 + 1), 32'd2, OP_ADD, TAG_W'(t), 32'(t * 16 + 3), 1'b0, w);
    end
    drain("bp_drain");
    chk("bp_rsp_count", 64'(n_rsp), 64'd8);

    // Prime 3 entries, then stream 20 back-to-back ops across the pointer wrap.
    n_rsp = 0;
    bus.rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      push_req(32'(t) << 8, 32'(t), OP_OR, TAG_W'(t + 8), (32'(t) << 8) | 32'(t), 1'b0, w);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("wrap_primed", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    stalls = 0;
    low    = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.rsp_valid) low++;
      case (i % 4)
        0: push_req(32'(i), 32'd1000, OP_ADD, TAG_W'(i), 32'(i) + 32'd1000, 1'b0, w);
        1: push_req(32'(i), 32'hffffffff, OP_XOR, TAG_W'(i), ~32'(i), 1'b0, w);
        2: push_req(32'(i), 32'(i), OP_SUB, TAG_W'(i), 32'd0, 1'b0, w);
        default: push_req(32'(i), 32'd0, OP_NOR, TAG_W'(i), ~32'(i), 1'b0, w);
      endcase
      stalls += w;
    end
    drain("wrap_drain");
    chk("wrap_no_stall", 64'(stalls), 64'd0);
    chk("wrap_one_per_cycle", 64'(low), 64'd0);
    chk("wrap_rsp_count", 64'(n_rsp), 64'd23);

    // Reset with 3 entries queued must flush everything immediately.
    bus.rsp_ready = 1'b0;
    for (int t = 1; t < 4; t++) begin
      push_req(32'(t), 32'(t), OP_ADD, TAG_W'(t), 32'(2 * t), 1'b0, w);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("mid_queued", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_fields", 64'({bus.rsp_tag, bus.rsp_over, bus.rsp_zero, bus.rsp_data}), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n  = 1'b1;
    hs_cnt = 0;
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);
    chk("mid_ops_done_clr", 64'(ops_done), 64'd0);

    // Response counter.
`ifdef ALU_RESP_STATS_EN
    for (int i = 0; i < 70000; i++) begin
      push_req(32'(i), 32'd1, OP_ADD, TAG_W'(i), 32'(i) + 32'd1, 1'b0, w);
    end
    drain("stats_drain");
    chk("stats_hs", 64'(hs_cnt), 64'd70000);
    chk("stats_ops_done", 64'(ops_done), 64'd4464);
`else
    for (int i = 0; i < 40; i++) begin
      push_req(32'(i), 32'd1, OP_ADD, TAG_W'(i), 32'(i) + 32'd1, 1'b0, w);
    end
    drain("stats_drain");
    chk("stats_hs", 64'(hs_cnt), 64'd40);
    chk("stats_ops_done_off", 64'(ops_done), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
